logic_result_stage: RTL and testbench

//  Output stage directly downstream of the ALU byte-partitioned logic unit. Captures the

---
 rtl/logic_result_stage_pkg.sv | 21 ++
 rtl/logic_result_stage_if.sv | 27 ++
 rtl/logic_result_fifo2.sv | 41 ++++
 rtl/logic_result_stage.sv | 42 ++++
 tb/tb_logic_result_stage.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/logic_result_stage_pkg.sv
// logic_result_stage_pkg: shared widths, entry layout and lane-mask helper for the logic result stage
package logic_result_stage_pkg;
   localparam int LANES = 4;
   localparam int BYTE_W = 8;
   localparam int WIDTH = LANES * BYTE_W;
   localparam int TAG_W = 5;
   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic z2;
      logic z1;
      logic [LANES-1:0] sel;
      logic [WIDTH-1:0] y2;
      logic [WIDTH-1:0] y1;
   } entry_t;
   localparam int ENTRY_W = $bits(entry_t);
   function automatic logic [WIDTH-1:0] lane_mask(input logic [LANES-1:0] sel);
      logic [WIDTH-1:0] m;
      for (int i = 0; i < LANES; i++) m[i*BYTE_W +: BYTE_W] = {BYTE_W{sel[i]}};
      return m;
   endfunction
endpackage

// File: rtl/logic_result_stage_if.sv
// logic_result_stage_if: upstream result and writeback handshake bundle
interface logic_result_stage_if;
   import logic_result_stage_pkg::*;
   logic in_valid;
   logic in_ready;
   logic [LANES-1:0] in_sel;
   logic [WIDTH-1:0] in_y1;
   logic [WIDTH-1:0] in_y2;
   logic [TAG_W-1:0] in_tag;
   logic out_valid;
   logic out_ready;
   logic [WIDTH-1:0] out_y1;
   logic [WIDTH-1:0] out_y2;
   logic [LANES-1:0] out_byte_en;
   logic [TAG_W-1:0] out_tag;
   logic out_z1;
   logic out_z2;
   logic [7:0] drop_count;
   modport slave (
      input in_valid, in_sel, in_y1, in_y2, in_tag, out_ready,
      output in_ready, out_valid, out_y1, out_y2, out_byte_en, out_tag, out_z1, out_z2, drop_count
   );
   modport master (
      output in_valid, in_sel, in_y1, in_y2, in_tag, out_ready,
      input in_ready, out_valid, out_y1, out_y2, out_byte_en, out_tag, out_z1, out_z2, drop_count
   );
endinterface

// File: rtl/logic_result_fifo2.sv
// logic_result_fifo2: 2-entry valid/ready FIFO with registered ready and register-only outputs
module logic_result_fifo2 #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push_valid,
   output logic         push_ready,
   input  logic [W-1:0] push_data,
   output logic         pop_valid,
   input  logic         pop_ready,
   output logic [W-1:0] pop_data
);
   logic [W-1:0] mem [2];
   logic [1:0] count, count_n;
   logic rd_ptr, wr_ptr, push, pop;
   assign push = push_valid & push_ready;
   assign pop = pop_valid & pop_ready;
   assign pop_valid = count != 2'd0;
   assign pop_data = mem[rd_ptr];
   always_comb count_n = (push && !pop) ? count + 2'd1 : (pop && !push) ? count - 2'd1 : count;
   // ready is registered from next count so it never depends on pop_ready combinationally
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= 2'd0;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         push_ready <= 1'b1;
         mem[0] <= '0;
         mem[1] <= '0;
      end else begin
         count <= count_n;
         push_ready <= count_n != 2'd2;
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
      end
   end
endmodule

// File: rtl/logic_result_stage.sv
// logic_result_stage: masks ALU logic results per byte lane, flags zeros and buffers them toward writeback
module logic_result_stage
   import logic_result_stage_pkg::*;
(
   input logic clk,
   input logic reset,
   logic_result_stage_if.slave bus
);
   entry_t in_e, out_e;
   logic [WIDTH-1:0] mask;
   logic [7:0] drops;
   always_comb begin
      mask = lane_mask(bus.in_sel);
      in_e.y1 = bus.in_y1 & mask;
      in_e.y2 = bus.in_y2 & mask;
      in_e.sel = bus.in_sel;
      in_e.z1 = ~|(bus.in_y1 & mask);
      in_e.z2 = ~|(bus.in_y2 & mask);
      in_e.tag = bus.in_tag;
   end
   logic_result_fifo2 #(.W(ENTRY_W)) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push_valid (bus.in_valid),
      .push_ready (bus.in_ready),
      .push_data  (in_e),
      .pop_valid  (bus.out_valid),
      .pop_ready  (bus.out_ready),
      .pop_data   (out_e)
   );
   assign bus.out_y1 = out_e.y1;
   assign bus.out_y2 = out_e.y2;
   assign bus.out_byte_en = out_e.sel;
   assign bus.out_tag = out_e.tag;
   assign bus.out_z1 = out_e.z1;
   assign bus.out_z2 = out_e.z2;
   assign bus.drop_count = drops;
   always_ff @(posedge clk) begin
      if (reset) drops <= 8'd0;
      else if (bus.in_valid && !bus.in_ready && drops != 8'hFF) drops <= drops + 8'd1;
   end
endmodule

// File: tb/tb_logic_result_stage.sv
// tb_logic_result_stage: directed scenario tests for the logic result stage
module tb_logic_result_stage;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int errors = 0;
   int checks = 0;
   logic_result_stage_if bus();
   logic_result_stage dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [3:0] sel, input logic [31:0] y1, input logic [31:0] y2, input logic [4:0] tag);
      bus.in_valid = v;
      bus.in_sel = sel;
      bus.in_y1 = y1;
      bus.in_y2 = y2;
      bus.in_tag = tag;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(1'b1, 4'hF, 32'h1234_5678, 32'h1, 5'd9);
      bus.out_ready = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      drive(1'b0, 4'h0, 32'h0, 32'h0, 5'd0);
      tick();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
      checks++; if ({bus.out_y1, bus.out_y2} !== 64'h0) begin errors++; $display("FAIL reset_y: got %h %h want 0 0", bus.out_y1, bus.out_y2); end
      checks++; if ({bus.out_tag, bus.out_byte_en, bus.out_z1, bus.out_z2} !== 11'h0) begin errors++; $display("FAIL reset_side: got tag=%h be=%h z=%b%b want 0", bus.out_tag, bus.out_byte_en, bus.out_z1, bus.out_z2); end
      checks++; if (bus.drop_count !== 8'd0) begin errors++; $display("FAIL reset_drop: got %0d want 0", bus.drop_count); end
   endtask

   task automatic test_basic();
      bus.out_ready = 1'b1;
      drive(1'b1, 4'hF, 32'hDEAD_BEEF, 32'h0, 5'd3);
      tick();
      drive(1'b0, 4'h0, 32'h0, 32'h0, 5'd0);
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", bus.out_valid); end
      checks++; if (bus.out_y1 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL basic_y1: got %h want deadbeef", bus.out_y1); end
      checks++; if (bus.out_y2 !== 32'h0) begin errors++; $display("FAIL basic_y2: got %h want 0", bus.out_y2); end
      checks++; if ({bus.out_z1, bus.out_z2} !== 2'b01) begin errors++; $display("FAIL basic_z: got %b%b want 01", bus.out_z1, bus.out_z2); end
      checks++; if (bus.out_byte_en !== 4'hF) begin errors++; $display("FAIL basic_be: got %h want f", bus.out_byte_en); end
      checks++; if (bus.out_tag !== 5'd3) begin errors++; $display("FAIL basic_tag: got %0d want 3", bus.out_tag); end
      tick();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain: got %b want 0", bus.out_valid); end
   endtask

   task automatic test_mask();
      bus.out_ready = 1'b1;
      drive(1'b1, 4'b0101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7);
      tick();
      drive(1'b0, 4'h0, 32'h0, 32'h0, 5'd0);
      checks++; if (bus.out_y1 !== 32'h00FF_00FF) begin errors++; $display("FAIL mask_y1: got %h want 00ff00ff", bus.out_y1); end
      checks++; if (bus.out_y2 !== 32'h00FF_00FF) begin errors++; $display("FAIL mask_y2: got %h want 00ff00ff", bus.out_y2); end
      checks++; if (bus.out_byte_en !== 4'b0101) begin errors++; $display("FAIL mask_be: got %b want 0101", bus.out_byte_en); end
      checks++; if ({bus.out_z1, bus.out_z2} !== 2'b00) begin errors++; $display("FAIL mask_z: got %b%b want 00", bus.out_z1, bus.out_z2); end
      tick();
      drive(1'b1, 4'b1010, 32'h00FF_00FF, 32'h1200_0000, 5'd12);
      tick();
      drive(1'b0, 4'h0, 32'h0, 32'h0, 5'd0);
      checks++; if ({bus.out_y1, bus.out_y2} !== {32'h0, 32'h1200_0000}) begin errors++; $display("FAIL mask_hi_y: got %h %h want 0 12000000", bus.out_y1, bus.out_y2); end
      checks++; if ({bus.out_z1, bus.out_z2} !== 2'b10) begin errors++; $display("FAIL mask_hi_z: got %b%b want 10", bus.out_z1, bus.out_z2); end
      tick();
      drive(1'b1, 4'b0000, 32'hFFFF_FFFF, 32'hA5A5_A5A5, 5'd31);
      tick();
      drive(1'b0, 4'h0, 32'h0, 32'h0, 5'd0);
      checks++; if ({bus.out_y1, bus.out_y2} !== 64'h0) begin errors++; $display("FAIL sel0_y: got %h %h want 0 0", bus.out_y1, bus.out_y2); end
      checks++; if ({bus.out_z1, bus.out_z2, bus.out_byte_en} !== 6'b11_0000) begin errors++; $display("FAIL sel0_flags: got z=%b%b be=%b want z=11 be=0000", bus.out_z1, bus.out_z2, bus.out_byte_en); end
      checks++; if (bus.out_tag !== 5'd31) begin errors++; $display("FAIL sel0_tag: got %0d want 31", bus.out_tag); end
      tick();
   endtask

   task automatic test_back_to_back();
      bus.out_ready = 1'b0;
      drive(1'b1, 4'hF, 32'h1111_1111, 32'h0, 5'd1);
      tick();
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready1: got %b want 1", bus.in_ready); end
      drive(1'b1, 4'hF, 32'h2222_2222, 32'h0, 5'd2);
      tick();
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready2: got %b want 0", bus.in_ready); end
      drive(1'b1, 4'hF, 32'h3333_3333, 32'h0, 5'd3);
      tick();
      drive(1'b0, 4'h0, 32'h0, 32'h0, 5'd0);
      checks++; if (bus.drop_count !== 8'd1) begin errors++; $display("FAIL b2b_drop: got %0d want 1", bus.drop_count); end
      checks++; if ({bus.out_valid, bus.out_tag, bus.out_y1} !== {1'b1, 5'd1, 32'h1111_1111}) begin errors++; $display("FAIL b2b_head: got v=%b tag=%0d y1=%h want v=1 tag=1 y1=11111111", bus.out_valid, bus.out_tag, bus.out_y1); end
      tick();
      checks++; if ({bus.out_tag, bus.in_ready} !== {5'd1, 1'b0}) begin errors++; $display("FAIL b2b_hold: got tag=%0d rdy=%b want tag=1 rdy=0", bus.out_tag, bus.in_ready); end
   endtask

   task automatic test_pop_push();
      bus.out_ready = 1'b1;
      drive(1'b1, 4'hF, 32'h4444_4444, 32'h0, 5'd4);
      tick();
      checks++; if ({bus.out_valid, bus.out_tag, bus.out_y1} !== {1'b1, 5'd2, 32'h2222_2222}) begin errors++; $display("FAIL pop_head: got v=%b tag=%0d y1=%h want v=1 tag=2 y1=22222222", bus.out_valid, bus.out_tag, bus.out_y1); end
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL pop_ready: got %b want 1", bus.in_ready); end
      checks++; if (bus.drop_count !== 8'd2) begin errors++; $display("FAIL pop_drop: got %0d want 2", bus.drop_count); end
      drive(1'b1, 4'b0011, 32'h5555_5555, 32'h0, 5'd5);
      tick();
      drive(1'b0, 4'h0, 32'h0, 32'h0, 5'd0);
      bus.out_ready = 1'b0;
      checks++; if ({bus.out_valid, bus.out_tag, bus.out_y1} !== {1'b1, 5'd5, 32'h0000_5555}) begin errors++; $display("FAIL pp_head: got v=%b tag=%0d y1=%h want v=1 tag=5 y1=00005555", bus.out_valid, bus.out_tag, bus.out_y1); end
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL pp_ready: got %b want 1", bus.in_ready); end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL pp_empty: got %b want 0", bus.out_valid); end
   endtask

   task automatic test_reset_held();
      bus.out_ready = 1'b0;
      drive(1'b1, 4'hF, 32'hAAAA_AAAA, 32'h1, 5'd10);
      tick();
      drive(1'b1, 4'hF, 32'hBBBB_BBBB, 32'h1, 5'd11);
      tick();
      drive(1'b1, 4'hF, 32'hCCCC_CCCC, 32'h1, 5'd12);
      tick();
      checks++; if (bus.drop_count === 8'd0) begin errors++; $display("FAIL rh_predrop: got %0d want nonzero", bus.drop_count); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      drive(1'b0, 4'h0, 32'h0, 32'h0, 5'd0);
      checks++; if ({bus.out_valid, bus.in_ready} !== 2'b01) begin errors++; $display("FAIL rh_hs: got v=%b rdy=%b want v=0 rdy=1", bus.out_valid, bus.in_ready); end
      checks++; if ({bus.out_y1, bus.out_y2, bus.out_tag, bus.out_byte_en, bus.out_z1, bus.out_z2} !== 75'h0) begin errors++; $display("FAIL rh_data: got y1=%h y2=%h tag=%h be=%h z=%b%b want 0", bus.out_y1, bus.out_y2, bus.out_tag, bus.out_byte_en, bus.out_z1, bus.out_z2); end
      checks++; if (bus.drop_count !== 8'd0) begin errors++; $display("FAIL rh_drop: got %0d want 0", bus.drop_count); end
      tick();
      checks++; if ({bus.out_valid, bus.in_ready} !== 2'b01) begin errors++; $display("FAIL rh_after: got v=%b rdy=%b want v=0 rdy=1", bus.out_valid, bus.in_ready); end
   endtask

   task automatic test_saturate();
      bus.out_ready = 1'b0;
      drive(1'b1, 4'hF, 32'h0000_0001, 32'h0, 5'd20);
      tick();
      drive(1'b1, 4'hF, 32'h0000_0002, 32'h0, 5'd21);
      tick();
      for (int i = 0; i < 10; i++) tick();
      checks++; if (bus.drop_count !== 8'd10) begin errors++; $display("FAIL sat_mid: got %0d want 10", bus.drop_count); end
      for (int i = 0; i < 290; i++) tick();
      checks++; if (bus.drop_count !== 8'hFF) begin errors++; $display("FAIL sat_drop: got %h want ff", bus.drop_count); end
      checks++; if ({bus.out_tag, bus.in_ready} !== {5'd20, 1'b0}) begin errors++; $display("FAIL sat_head: got tag=%0d rdy=%b want tag=20 rdy=0", bus.out_tag, bus.in_ready); end
      drive(1'b0, 4'h0, 32'h0, 32'h0, 5'd0);
      bus.out_ready = 1'b1;
      tick();
      tick();
      checks++; if ({bus.out_valid, bus.drop_count} !== {1'b0, 8'hFF}) begin errors++; $display("FAIL sat_keep: got v=%b drop=%h want v=0 drop=ff", bus.out_valid, bus.drop_count); end
   endtask

   initial begin
      bus.out_ready = 1'b0;
      drive(1'b0, 4'h0, 32'h0, 32'h0, 5'd0);
      test_reset();
      test_basic();
      test_mask();
      test_back_to_back();
      test_pop_push();
      test_reset_held();
      test_saturate();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
